// File: rtl/spram_ctrl_pkg.sv
// Shared constants and FSM state type for the SPRAM request controller.
package spram_ctrl_pkg;

   localparam int unsigned CTRL_DW    = 32;
   localparam int unsigned BE_W       = CTRL_DW / 8;
   localparam int unsigned FIFO_DEPTH = 2;
   localparam int unsigned CNT_W      = $clog2(FIFO_DEPTH + 1);

   typedef enum logic {
      CLEAR,
      RUN
   } ctrl_state_e;

endpackage

// File: rtl/spram_rsp_fifo2.sv
// Two-entry first-word-fall-through FIFO holding SPRAM read responses.
module spram_rsp_fifo2
   import spram_ctrl_pkg::*;
#(
   parameter int unsigned DW = 32
) (
   input  logic             clk_i,
   input  logic             rstn_i,
   input  logic             push_i,
   input  logic [DW-1:0]    din_i,
   input  logic             pop_i,
   output logic             valid_o,
   output logic [DW-1:0]    dout_o,
   output logic [CNT_W-1:0] count_o
);

   logic [DW-1:0]    head_q;
   logic [DW-1:0]    tail_q;
   logic [CNT_W-1:0] count_q;
   logic             pop;

   assign pop     = pop_i & (count_q != '0);
   assign valid_o = (count_q != '0);
   assign dout_o  = head_q;
   assign count_o = count_q;

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         case ({push_i, pop})
            2'b10: begin
               if (count_q == '0) head_q <= din_i;
               else               tail_q <= din_i;
               count_q <= count_q + CNT_W'(1);
            end
            2'b01: begin
               head_q  <= tail_q;
               count_q <= count_q - CNT_W'(1);
            end
            2'b11: begin
               // Count stays; the new word lands behind whatever remains
               if (count_q == CNT_W'(1)) begin
                  head_q <= din_i;
               end else begin
                  head_q <= tail_q;
                  tail_q <= din_i;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/spram_req_ctrl.sv
// Valid/ready front-end for the single-port SPRAM: optional zero-fill after
// reset, then request pass-through with credit-limited read responses.
module spram_req_ctrl
   import spram_ctrl_pkg::*;
#(
   parameter int unsigned AW           = 14,
   parameter int unsigned DW           = 32,
   parameter bit          CLEAR_ON_RST = 1'b1
) (
   input  logic            clk_i,
   input  logic            rstn_i,
   input  logic            req_valid_i,
   output logic            req_ready_o,
   input  logic            req_we_i,
   input  logic [AW-1:0]   req_addr_i,
   input  logic [BE_W-1:0] req_be_i,
   input  logic [DW-1:0]   req_wdata_i,
   output logic            rsp_valid_o,
   input  logic            rsp_ready_i,
   output logic [DW-1:0]   rsp_rdata_o,
   output logic            init_done_o,
   output logic [AW-1:0]   mem_addr_o,
   output logic            mem_wr_en_o,
   output logic [BE_W-1:0] mem_mask_we_o,
   output logic [DW-1:0]   mem_wr_data_o,
   input  logic [DW-1:0]   mem_rd_data_i
);

   ctrl_state_e      state_q, state_d;
   logic [AW-1:0]    clr_cnt_q;
   logic             inflight_q;
   logic [CNT_W-1:0] fifo_count;
   logic [CNT_W:0]   occ_after_pop;
   logic             rsp_pop;
   logic             rd_fire;
   logic             clr_last;

   assign clr_last    = (clr_cnt_q == '1);
   assign rsp_pop     = rsp_valid_o & rsp_ready_i;
   assign rd_fire     = req_valid_i & req_ready_o & ~req_we_i;
   assign init_done_o = (state_q == RUN);

   // A same-cycle pop frees a slot, which sustains one read per cycle
   assign occ_after_pop = (CNT_W+1)'(fifo_count) + (CNT_W+1)'(inflight_q)
                        - (CNT_W+1)'(rsp_pop);

   always_comb begin
      state_d       = state_q;
      req_ready_o   = 1'b0;
      mem_addr_o    = req_addr_i;
      mem_wr_en_o   = 1'b0;
      mem_mask_we_o = '0;
      mem_wr_data_o = req_wdata_i;
      case (state_q)
         CLEAR: begin
            mem_addr_o    = clr_cnt_q;
            mem_wr_en_o   = rstn_i;
            mem_mask_we_o = '1;
            mem_wr_data_o = '0;
            if (clr_last) state_d = RUN;
         end
         RUN: begin
            req_ready_o   = rstn_i &
                            (req_we_i | (occ_after_pop < (CNT_W+1)'(FIFO_DEPTH)));
            mem_wr_en_o   = req_valid_i & req_ready_o & req_we_i;
            mem_mask_we_o = mem_wr_en_o ? req_be_i : '0;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state_q    <= CLEAR_ON_RST ? CLEAR : RUN;
         clr_cnt_q  <= '0;
         inflight_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         inflight_q <= rd_fire;
         if (state_q == CLEAR && !clr_last) clr_cnt_q <= clr_cnt_q + AW'(1);
      end
   end

   spram_rsp_fifo2 #(
      .DW (DW)
   ) u_rsp_fifo (
      .clk_i   (clk_i),
      .rstn_i  (rstn_i),
      .push_i  (inflight_q),
      .din_i   (mem_rd_data_i),
      .pop_i   (rsp_pop),
      .valid_o (rsp_valid_o),
      .dout_o  (rsp_rdata_o),
      .count_o (fifo_count)
   );

endmodule

// File: tb/tb_spram_req_ctrl.sv
// Self-checking bench for spram_req_ctrl with a behavioural SPRAM and a
// transaction-level reference of memory contents and response order.
module tb_spram_req_ctrl;

   localparam int unsigned AW    = 14;
   localparam int unsigned DEPTH = 1 << AW;

   logic          clk_i = 1'b0;
   logic          rstn_i = 1'b0;
   logic          req_valid_i = 1'b0;
   logic          req_ready_o;
   logic          req_we_i = 1'b0;
   logic [AW-1:0] req_addr_i = '0;
   logic [3:0]    req_be_i = '0;
   logic [31:0]   req_wdata_i = '0;
   logic          rsp_valid_o;
   logic          rsp_ready_i = 1'b0;
   logic [31:0]   rsp_rdata_o;
   logic          init_done_o;
   logic [AW-1:0] mem_addr_o;
   logic          mem_wr_en_o;
   logic [3:0]    mem_mask_we_o;
   logic [31:0]   mem_wr_data_o;
   logic [31:0]   mem_rd_data_i;

   spram_req_ctrl #(
      .AW           (AW),
      .DW           (32),
      .CLEAR_ON_RST (1'b1)
   ) dut (
      .clk_i         (clk_i),
      .rstn_i        (rstn_i),
      .req_valid_i   (req_valid_i),
      .req_ready_o   (req_ready_o),
      .req_we_i      (req_we_i),
      .req_addr_i    (req_addr_i),
      .req_be_i      (req_be_i),
      .req_wdata_i   (req_wdata_i),
      .rsp_valid_o   (rsp_valid_o),
      .rsp_ready_i   (rsp_ready_i),
      .rsp_rdata_o   (rsp_rdata_o),
      .init_done_o   (init_done_o),
      .mem_addr_o    (mem_addr_o),
      .mem_wr_en_o   (mem_wr_en_o),
      .mem_mask_we_o (mem_mask_we_o),
      .mem_wr_data_o (mem_wr_data_o),
      .mem_rd_data_i (mem_rd_data_i)
   );

   always #5 clk_i = ~clk_i;

   int unsigned n_chk  = 0;
   int unsigned n_fail = 0;
   int unsigned cyc    = 0;
   int unsigned n_pops = 0;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                         input logic [3:0] be);
      logic [31:0] r;
      r = old;
      for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = d[8*b +: 8];
      return r;
   endfunction

   // Behavioural SPRAM: registered read, masked write
   logic [31:0] sram [DEPTH];
   always @(posedge clk_i) begin
      if (mem_wr_en_o) sram[mem_addr_o] <= merge(sram[mem_addr_o], mem_wr_data_o, mem_mask_we_o);
      mem_rd_data_i <= sram[mem_addr_o];
   end

   always @(posedge clk_i) cyc++;

   // Reference: memory image after clear, queue of outstanding reads
   typedef struct {
      logic [31:0] data;
      int unsigned cyc;
   } exp_t;

   logic [31:0] ref_mem [DEPTH];
   exp_t        expq[$];
   exp_t        e;
   bit          mon_en = 1'b0;
   int unsigned outstanding;
   bit          pop_now;
   bit          exp_valid;

   always @(negedge clk_i) begin
      if (mon_en && rstn_i) begin
         outstanding = expq.size();
         pop_now     = rsp_valid_o && rsp_ready_i;
         exp_valid   = (outstanding > 0) && ((cyc - expq[0].cyc) >= 2);
         check("rsp_valid", rsp_valid_o, exp_valid);
         check("req_ready", req_ready_o,
               req_we_i ? 1 : ((outstanding - (pop_now ? 1 : 0)) < 2));
         if (pop_now && outstanding > 0) begin
            e = expq.pop_front();
            check("rsp_data", rsp_rdata_o, e.data);
            n_pops++;
         end
         check("mem_we", mem_wr_en_o, req_valid_i && req_ready_o && req_we_i);
         if (req_valid_i && req_ready_o) begin
            check("mem_addr", mem_addr_o, req_addr_i);
            if (req_we_i) begin
               check("mem_mask", mem_mask_we_o, req_be_i);
               check("mem_wdata", mem_wr_data_o, req_wdata_i);
               ref_mem[req_addr_i] = merge(ref_mem[req_addr_i], req_wdata_i, req_be_i);
            end else begin
               expq.push_back('{ref_mem[req_addr_i], cyc});
            end
         end
      end
   end

   task automatic reset_and_clear();
      int unsigned n, bad;
      mon_en      = 1'b0;
      rstn_i      = 1'b0;
      req_valid_i = 1'b0;
      req_we_i    = 1'b0;
      rsp_ready_i = 1'b0;
      repeat (3) @(posedge clk_i);
      #1;
      check("rst_ready", req_ready_o, 0);
      check("rst_rsp_valid", rsp_valid_o, 0);
      check("rst_rdata", rsp_rdata_o, 0);
      check("rst_init_done", init_done_o, 0);
      @(negedge clk_i);
      rstn_i = 1'b1;
      #1;
      n   = 0;
      bad = 0;
      while (!init_done_o && n < DEPTH + 8) begin
         if (!(mem_wr_en_o && mem_mask_we_o == 4'hF && mem_wr_data_o == 32'h0 &&
               mem_addr_o == AW'(n) && !req_ready_o && !rsp_valid_o)) bad++;
         @(posedge clk_i);
         #1;
         n++;
      end
      check("clr_cycles", n, DEPTH);
      check("clr_bad_cycles", bad, 0);
      check("post_clr_rsp_valid", rsp_valid_o, 0);
      for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
      expq.delete();
      mon_en = 1'b1;
   endtask

   // Entered and left at 1 time unit after a rising edge
   task automatic issue(input bit we, input logic [AW-1:0] a, input logic [3:0] be,
                        input logic [31:0] d, output int unsigned waited);
      req_valid_i = 1'b1;
      req_we_i    = we;
      req_addr_i  = a;
      req_be_i    = be;
      req_wdata_i = d;
      waited      = 0;
      #1;
      while (!req_ready_o && waited < 50) begin
         @(posedge clk_i);
         #2;
         waited++;
      end
      check("issue_accept", req_ready_o, 1);
      @(posedge clk_i);
      #1;
      req_valid_i = 1'b0;
   endtask

   int unsigned w, p0, k;

   initial begin
      for (int i = 0; i < DEPTH; i++) sram[i] = $urandom;

      reset_and_clear();
      @(posedge clk_i);
      #1;

      // Write then read with latency 2
      rsp_ready_i = 1'b1;
      issue(1'b1, AW'('h0123), 4'hF, 32'hDEADBEEF, w);
      issue(1'b0, AW'('h0123), 4'h0, 32'h0, w);
      check("wr_rd_lat1_valid", rsp_valid_o, 0);
      @(posedge clk_i);
      #1;
      check("wr_rd_lat2_valid", rsp_valid_o, 1);
      check("wr_rd_data", rsp_rdata_o, 32'hDEADBEEF);
      @(posedge clk_i);
      #1;

      // Byte-enable merge
      issue(1'b1, AW'(5), 4'hF, 32'h11223344, w);
      issue(1'b1, AW'(5), 4'b0101, 32'hAABBCCDD, w);
      issue(1'b1, AW'(6), 4'h0, 32'hFFFFFFFF, w);
      issue(1'b0, AW'(5), 4'h0, 32'h0, w);
      @(posedge clk_i);
      #1;
      check("be_data", rsp_rdata_o, 32'h11BB33DD);
      @(posedge clk_i);
      #1;
      issue(1'b0, AW'(6), 4'h0, 32'h0, w);
      @(posedge clk_i);
      #1;
      check("be_zero_data", rsp_rdata_o, 32'h0);
      @(posedge clk_i);
      #1;

      // Streaming reads
      for (int i = 0; i < 8; i++) issue(1'b1, AW'(i), 4'hF, $urandom, w);
      p0 = n_pops;
      for (int i = 0; i < 8; i++) begin
         issue(1'b0, AW'(i), 4'h0, 32'h0, w);
         check("stream_no_wait", w, 0);
      end
      repeat (3) @(posedge clk_i);
      #1;
      check("stream_pops", n_pops - p0, 8);

      // Backpressure
      rsp_ready_i = 1'b0;
      issue(1'b1, AW'('h10), 4'hF, 32'hA5A5_0010, w);
      issue(1'b1, AW'('h11), 4'hF, 32'hA5A5_0011, w);
      issue(1'b0, AW'('h10), 4'h0, 32'h0, w);
      check("bp_rd1_no_wait", w, 0);
      issue(1'b0, AW'('h11), 4'h0, 32'h0, w);
      check("bp_rd2_no_wait", w, 0);
      repeat (3) @(posedge clk_i);
      #1;
      req_we_i = 1'b0;
      #1;
      check("bp_rd_blocked", req_ready_o, 0);
      req_we_i = 1'b1;
      #1;
      check("bp_wr_ready", req_ready_o, 1);
      check("bp_head", rsp_rdata_o, 32'hA5A5_0010);
      @(posedge clk_i);
      #1;
      p0 = n_pops;
      rsp_ready_i = 1'b1;
      issue(1'b0, AW'('h12), 4'h0, 32'h0, w);
      repeat (3) @(posedge clk_i);
      #1;
      check("bp_drain_pops", n_pops - p0, 3);

      // Random traffic against the reference
      for (int i = 0; i < 1500; i++) begin
         req_valid_i = ($urandom_range(0, 3) != 0);
         req_we_i    = $urandom_range(0, 1);
         req_addr_i  = AW'($urandom_range(0, 15));
         req_be_i    = 4'($urandom);
         req_wdata_i = $urandom;
         rsp_ready_i = ($urandom_range(0, 3) != 0);
         @(posedge clk_i);
         #1;
      end
      req_valid_i = 1'b0;
      rsp_ready_i = 1'b1;
      k = 0;
      while (expq.size() != 0 && k < 20) begin
         @(posedge clk_i);
         #1;
         k++;
      end
      check("rand_drained", expq.size(), 0);

      // Reset with two responses queued
      rsp_ready_i = 1'b0;
      issue(1'b0, AW'(1), 4'h0, 32'h0, w);
      issue(1'b0, AW'(2), 4'h0, 32'h0, w);
      repeat (2) @(posedge clk_i);
      #1;
      check("pre_rst_valid", rsp_valid_o, 1);
      mon_en = 1'b0;
      #1;
      rstn_i = 1'b0;
      #1;
      check("async_rst_valid", rsp_valid_o, 0);
      reset_and_clear();
      @(posedge clk_i);
      #1;
      rsp_ready_i = 1'b1;
      issue(1'b0, AW'(5), 4'h0, 32'h0, w);
      @(posedge clk_i);
      #1;
      check("post_rst_valid", rsp_valid_o, 1);
      check("post_rst_cleared", rsp_rdata_o, 32'h0);
      repeat (3) @(posedge clk_i);
      #1;

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d",
               n_chk, n_fail);
      $fatal(1);
   end

endmodule
